// File: rtl/set_mode_ctrl.sv
// set_mode_ctrl
//   Alarm-clock set/display mode sequencer. Converts the debounced MODE/NEXT/INC
//   button levels into the mode code S, the two digit cursors CW (alarm) and
//   CW1 (time), the BLINK phase for the blinker, and one-cycle increment
//   strobes for the time and alarm counters.
//
//   Ports
//     CLK        in   system clock, rising edge
//     RST        in   synchronous reset, active-high
//     MODE_BTN   in   rising edge advances RUN->SET_TIME->SET_ALARM->VIEW_ALARM->RUN
//     NEXT_BTN   in   rising edge moves the active cursor to the next digit
//     INC_BTN    in   rising edge increments the digit under the active cursor
//     S          out  mode: 00 RUN, 10 SET_TIME, 11 SET_ALARM, 01 VIEW_ALARM
//     CW         out  alarm-digit cursor 0..3
//     CW1        out  time-digit cursor 0..3
//     BLINK      out  blink phase, 1 = digit visible
//     INC_TIME   out  one-cycle strobe, increment time digit CW1
//     INC_ALARM  out  one-cycle strobe, increment alarm digit CW
module set_mode_ctrl #(
    parameter int BLINK_DIV       = 25000000,
    parameter int TIMEOUT_TOGGLES = 20
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       MODE_BTN,
    input  logic       NEXT_BTN,
    input  logic       INC_BTN,
    output logic [1:0] S,
    output logic [1:0] CW,
    output logic [1:0] CW1,
    output logic       BLINK,
    output logic       INC_TIME,
    output logic       INC_ALARM
);

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_TOGGLES + 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_TOGGLES - 1);

    // Encodings are the S output codes, so the state register drives S directly.
    typedef enum logic [1:0] {
        RUN        = 2'b00,
        VIEW_ALARM = 2'b01,
        SET_TIME   = 2'b10,
        SET_ALARM  = 2'b11
    } state_t;

    state_t        state, state_n;
    logic [1:0]    cw, cw_n, cw1, cw1_n;
    logic          blink, blink_n;
    logic          inc_time, inc_time_n, inc_alarm, inc_alarm_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          prev_mode, prev_next, prev_inc;

    logic mode_raw, next_raw, inc_raw;
    logic mode_e, next_e, inc_e, editing;

    // prev registers reset to 1 so a button held through reset is not an edge.
    assign mode_raw = MODE_BTN & ~prev_mode;
    assign next_raw = NEXT_BTN & ~prev_next;
    assign inc_raw  = INC_BTN  & ~prev_inc;

    // Priority MODE > NEXT > INC; a losing edge is dropped, not deferred.
    assign mode_e = mode_raw;
    assign next_e = next_raw & ~mode_raw;
    assign inc_e  = inc_raw  & ~mode_raw & ~next_raw;

    assign editing = (state == SET_TIME) || (state == SET_ALARM);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            cw        <= 2'd0;
            cw1       <= 2'd0;
            blink     <= 1'b1;
            inc_time  <= 1'b0;
            inc_alarm <= 1'b0;
            bcnt      <= '0;
            tcnt      <= '0;
            prev_mode <= 1'b1;
            prev_next <= 1'b1;
            prev_inc  <= 1'b1;
        end else begin
            state     <= state_n;
            cw        <= cw_n;
            cw1       <= cw1_n;
            blink     <= blink_n;
            inc_time  <= inc_time_n;
            inc_alarm <= inc_alarm_n;
            bcnt      <= bcnt_n;
            tcnt      <= tcnt_n;
            prev_mode <= MODE_BTN;
            prev_next <= NEXT_BTN;
            prev_inc  <= INC_BTN;
        end
    end

    always_comb begin
        state_n     = state;
        cw_n        = cw;
        cw1_n       = cw1;
        blink_n     = blink;
        inc_time_n  = 1'b0;
        inc_alarm_n = 1'b0;
        bcnt_n      = bcnt;
        tcnt_n      = tcnt;

        if (mode_e) begin
            // Every state change restarts blink and timeout with the digit shown.
            bcnt_n  = '0;
            tcnt_n  = '0;
            blink_n = 1'b1;
            case (state)
                RUN: begin
                    state_n = SET_TIME;
                    cw1_n   = 2'd0;
                end
                SET_TIME: begin
                    state_n = SET_ALARM;
                    cw_n    = 2'd0;
                end
                SET_ALARM:  state_n = VIEW_ALARM;
                VIEW_ALARM: state_n = RUN;
                default:    state_n = RUN;
            endcase
        end else if (editing) begin
            if (next_e || inc_e) begin
                bcnt_n  = '0;
                tcnt_n  = '0;
                blink_n = 1'b1;
                if (next_e) begin
                    if (state == SET_TIME) cw1_n = cw1 + 2'd1;
                    else                   cw_n  = cw + 2'd1;
                end else begin
                    if (state == SET_TIME) inc_time_n  = 1'b1;
                    else                   inc_alarm_n = 1'b1;
                end
            end else if (bcnt == B_LAST) begin
                bcnt_n = '0;
                if (tcnt == T_LAST) begin
                    // Final toggle: abandon editing, cursors are left as they are.
                    state_n = RUN;
                    blink_n = 1'b1;
                    tcnt_n  = '0;
                end else begin
                    blink_n = ~blink;
                    tcnt_n  = tcnt + 1'b1;
                end
            end else begin
                bcnt_n = bcnt + 1'b1;
            end
        end else begin
            bcnt_n  = '0;
            tcnt_n  = '0;
            blink_n = 1'b1;
        end
    end

    assign S         = state;
    assign CW        = cw;
    assign CW1       = cw1;
    assign BLINK     = blink;
    assign INC_TIME  = inc_time;
    assign INC_ALARM = inc_alarm;

endmodule
